// File: rtl/proc_pkg.sv
// Shared opcode, instruction-word and FSM definitions for the 8-bit core's
// instruction side.
package proc_pkg;

   localparam logic [3:0] OP_ROT = 4'b0000;
   localparam logic [3:0] OP_MVA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_INR = 4'b0101;
   localparam logic [3:0] OP_DCR = 4'b0110;
   localparam logic [3:0] OP_ADI = 4'b0111;
   localparam logic [3:0] OP_HLT = 4'b1000;
   localparam logic [3:0] OP_SBI = 4'b1001;
   localparam logic [3:0] OP_REG = 4'b1010;
   localparam logic [3:0] OP_MOV = 4'b1011;
   localparam logic [3:0] OP_MVI = 4'b1100;
   localparam logic [3:0] OP_OR  = 4'b1101;
   localparam logic [3:0] OP_AND = 4'b1110;
   localparam logic [3:0] OP_XOR = 4'b1111;

   localparam int IW     = 18;
   localparam int OP_LSB = 14;
   localparam int RA_LSB = 11;
   localparam int RB_LSB = 8;

   // [17:14] op, [13:11] ra, [10:8] rb, [7:0] imm
   typedef struct packed {
      logic [3:0] op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: one synchronous write port, one synchronous read port.
// A read of the address being written returns the new word.
module prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 18
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/instr_issue_unit.sv
// Fetches words from prog_mem in order and presents each to the core
// for its execution latency, with one bubble between instructions.
module instr_issue_unit
   import proc_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int LAT_ALU = 2,
   parameter int LAT_MUL = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stall,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   output logic [3:0]    bit1,
   output logic [2:0]    bit2,
   output logic [2:0]    bit3,
   output logic [7:0]    bit4,
   output logic          issue_valid,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic          busy
);

   localparam int CW = 4;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] rdata;
   instr_t        word;
   logic          idle_like;
   logic          go_start;
   logic          go_next;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          wr_en;

   function automatic logic [CW-1:0] lat_m1(input logic [3:0] op);
      logic [CW-1:0] r;
      r = '0;
      unique case (op)
         OP_MUL:
            r = CW'(LAT_MUL - 1);
         OP_ADD, OP_SUB, OP_INR, OP_DCR, OP_ADI, OP_SBI:
            r = CW'(LAT_ALU - 1);
         default:
            r = '0;
      endcase
      return r;
   endfunction

   // Read is launched on the edge that enters FETCH, so the word is
   // ready to be registered onto the outputs at the end of FETCH.
   always_comb begin
      idle_like = (state == S_IDLE) || (state == S_HALT);
      go_start  = idle_like && start && !stall;
      go_next   = (state == S_ISSUE) && (cnt == '0)
                  && (bit1 != OP_HLT) && !stall;
      rd_en     = go_start || go_next;
      rd_addr   = go_start ? '0 : pc + AW'(1);
      wr_en     = prog_we && idle_like;
      word      = instr_t'(rdata);
   end

   prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (IW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         cnt         <= '0;
         bit1        <= OP_HLT;
         bit2        <= '0;
         bit3        <= '0;
         bit4        <= '0;
         issue_valid <= 1'b0;
         halted      <= 1'b0;
         busy        <= 1'b0;
      end else if (!stall) begin
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state  <= S_FETCH;
                  pc     <= '0;
                  halted <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            S_FETCH: begin
               bit1        <= word.op;
               bit2        <= word.ra;
               bit3        <= word.rb;
               bit4        <= word.imm;
               issue_valid <= 1'b1;
               cnt         <= lat_m1(word.op);
               state       <= S_ISSUE;
            end
            S_ISSUE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  issue_valid <= 1'b0;
                  bit1        <= OP_HLT;
                  bit2        <= '0;
                  bit3        <= '0;
                  bit4        <= '0;
                  // HLT has had its single presented cycle; park here
                  if (bit1 == OP_HLT) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                     busy   <= 1'b0;
                  end else begin
                     state <= S_FETCH;
                     pc    <= pc + AW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: load, run, stall, reset, wrap and
// write-protection scenarios with hand-computed expectations.
module tb_instr_issue_unit;
   import proc_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stall;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [17:0] prog_data;
   logic [3:0]  bit1;
   logic [2:0]  bit2;
   logic [2:0]  bit3;
   logic [7:0]  bit4;
   logic        issue_valid;
   logic [3:0]  pc;
   logic        halted;
   logic        busy;

   int errs   = 0;
   int checks = 0;

   instr_issue_unit #(
      .DEPTH(16), .AW(4), .LAT_ALU(2), .LAT_MUL(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .bit1(bit1), .bit2(bit2), .bit3(bit3), .bit4(bit4),
      .issue_valid(issue_valid), .pc(pc), .halted(halted), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] ins(input logic [3:0] op,
      input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
      return {op, ra, rb, imm};
   endfunction

   task automatic load(input logic [3:0] a, input logic [17:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   logic [3:0] e_op [1:9];
   logic       e_v  [1:9];
   logic [3:0] e_pc [1:9];

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_bit1", bit1, 4'b1000);
      check("rst_valid", issue_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_pc", pc, 0);
      check("rst_fields", {bit2, bit3, bit4}, 0);

      // MVI then HLT
      load(0, ins(OP_MVI, 3'd2, 3'd0, 8'h3C));
      load(1, ins(OP_HLT, 0, 0, 0));
      go();
      check("fetch_busy", busy, 1);
      check("fetch_valid", issue_valid, 0);
      tick();
      check("mvi_bit1", bit1, 4'hC);
      check("mvi_bit2", bit2, 2);
      check("mvi_bit4", bit4, 8'h3C);
      check("mvi_valid", issue_valid, 1);
      tick();
      check("mvi_bub_v", issue_valid, 0);
      check("mvi_bub_op", bit1, 4'h8);
      check("mvi_bub_pc", pc, 1);
      tick();
      check("hlt_valid", issue_valid, 1);
      check("hlt_halted", halted, 0);
      tick();
      check("hlt_halted2", halted, 1);
      check("hlt_pc", pc, 1);
      check("hlt_busy", busy, 0);
      check("hlt_valid2", issue_valid, 0);

      // MUL, ADD, HLT timeline
      load(0, ins(OP_MUL, 3'd1, 3'd3, 8'h00));
      load(1, ins(OP_ADD, 3'd0, 3'd4, 8'h00));
      load(2, ins(OP_HLT, 0, 0, 0));
      e_op = '{4'h4, 4'h4, 4'h4, 4'h8, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8};
      e_v  = '{1, 1, 1, 0, 1, 1, 0, 1, 0};
      e_pc = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
      go();
      for (int i = 1; i <= 9; i++) begin
         tick();
         check($sformatf("seq_op%0d", i), bit1, e_op[i]);
         check($sformatf("seq_v%0d", i), issue_valid, e_v[i]);
         check($sformatf("seq_pc%0d", i), pc, e_pc[i]);
         check($sformatf("seq_h%0d", i), halted, (i == 9) ? 1 : 0);
         if (i == 1) check("mul_regs", {bit2, bit3}, {3'd1, 3'd3});
         if (i == 5) check("add_regs", {bit2, bit3}, {3'd0, 3'd4});
      end

      // stall together with start in HALT is ignored
      stall = 1'b1; start = 1'b1;
      tick();
      stall = 1'b0; start = 1'b0;
      check("stst_halted", halted, 1);
      check("stst_busy", busy, 0);

      // async reset in the middle of a MUL
      go();
      tick();
      tick();
      check("mid_mul", bit1, 4'h4);
      rst = 1'b1;
      #1;
      check("arst_bit1", bit1, 4'h8);
      check("arst_valid", issue_valid, 0);
      check("arst_pc", pc, 0);
      check("arst_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      check("arst_idle", {busy, halted, issue_valid}, 0);

      // stall during the second ADD cycle
      go();
      repeat (6) tick();
      check("add2_op", bit1, 4'h2);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("stall_op%0d", i), bit1, 4'h2);
         check($sformatf("stall_v%0d", i), issue_valid, 1);
         check($sformatf("stall_pc%0d", i), pc, 1);
      end
      stall = 1'b0;
      tick();
      check("unstall_bub", issue_valid, 0);
      check("unstall_pc", pc, 2);
      tick();
      check("unstall_hlt", {bit1, issue_valid}, {4'h8, 1'b1});
      tick();
      check("unstall_halt", halted, 1);

      // HLT-free program wraps from 15 to 0
      load(0, ins(OP_MVI, 3'd1, 3'd0, 8'h11));
      for (int a = 1; a < 15; a++)
         load(4'(a), ins(OP_MOV, 3'd0, 3'd1, 8'(a)));
      load(15, ins(OP_OR, 3'd0, 3'd0, 8'h0F));
      go();
      tick();
      check("wrap_e1", bit1, 4'hC);
      // write while busy must not land
      prog_we = 1'b1; prog_addr = 1; prog_data = ins(OP_HLT, 0, 0, 0);
      tick();
      prog_we = 1'b0;
      tick();
      check("wp_op", bit1, 4'hB);
      check("wp_imm", bit4, 8'h01);
      repeat (28) tick();
      check("wrap_pc15", pc, 15);
      check("wrap_or", {bit1, bit4}, {4'hD, 8'h0F});
      tick();
      check("wrap_bub_pc", pc, 0);
      tick();
      check("wrap_addr0", {bit1, bit4}, {4'hC, 8'h11});
      check("wrap_valid", issue_valid, 1);

      // return to HALT, then write with start in the same cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load(0, ins(OP_HLT, 0, 0, 0));
      go();
      repeat (2) tick();
      check("h2_halted", halted, 1);
      prog_we = 1'b1; prog_addr = 0;
      prog_data = ins(OP_MVI, 3'd3, 3'd0, 8'h5A);
      start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      check("h2_fetch", {busy, halted}, {1'b1, 1'b0});
      tick();
      check("h2_op", bit1, 4'hC);
      check("h2_ra", bit2, 3);
      check("h2_imm", bit4, 8'h5A);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
